carry_select_subtractor_pipe: RTL and testbench

Pipelined, handshaked N-bit subtractor computing a − b − bin. It is the inverse-operation companion to the team's combinational carry-select adder. The operand is split into BLOCK-bit slices. Each pipeline stage resolves one slice by carry-select: it precomputes the difference for borrow-in 0 and borrow-in 1, then selects using the registered borrow from the previous stage. The block sits in the benchmarking datapath as a throughput-1 arithmetic unit with valid/ready flow control on both sides.

---
 rtl/carry_select_subtractor_pipe.sv | 113 +++++++++++
 tb/tb_carry_select_subtractor_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_pipe.sv
// Pipelined carry-select subtractor: diff = a - b - bin, one BLOCK-bit slice resolved per stage.
// Valid/ready on both ends; the whole pipe freezes while the output is held by the consumer.
module carry_select_subtractor_pipe #(
    parameter int N     = 16,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int S = N / BLOCK;

    if (BLOCK < 1 || N % BLOCK != 0) begin : g_bad_params
        $error("carry_select_subtractor_pipe: N must be a positive multiple of BLOCK");
    end

    // Slice difference with its borrow out in the top bit.
    function automatic logic [BLOCK:0] slice_sub(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             bw);
        return {1'b0, x} - {1'b0, y} - {{BLOCK{1'b0}}, bw};
    endfunction

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int REM = N - s * BLOCK;

        logic [REM-1:0]         a_in;
        logic [REM-1:0]         b_in;
        logic                   bor_in;
        logic                   vld_in;
        logic [BLOCK:0]         d0;
        logic [BLOCK:0]         d1;
        logic [BLOCK:0]         sel;
        logic [(s+1)*BLOCK-1:0] diff_nx;
        logic [(s+1)*BLOCK-1:0] diff_p;
        logic                   bor_p;
        logic                   vld_p;

        // Stage boundary: stage s consumes the unprocessed operand bits left by stage s-1.
        if (s == 0) begin : g_src
            assign a_in    = a;
            assign b_in    = b;
            assign bor_in  = bin;
            assign vld_in  = in_valid;
            assign diff_nx = sel[BLOCK-1:0];
        end else begin : g_src
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_in <= '0;
                    b_in <= '0;
                end else if (!stall) begin
                    a_in <= g_stage[s-1].a_in[REM+BLOCK-1:BLOCK];
                    b_in <= g_stage[s-1].b_in[REM+BLOCK-1:BLOCK];
                end
            end
            assign bor_in  = g_stage[s-1].bor_p;
            assign vld_in  = g_stage[s-1].vld_p;
            assign diff_nx = {sel[BLOCK-1:0], g_stage[s-1].diff_p};
        end

        assign d0  = slice_sub(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b0);
        assign d1  = slice_sub(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b1);
        assign sel = bor_in ? d1 : d0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                diff_p <= '0;
                bor_p  <= 1'b0;
                vld_p  <= 1'b0;
            end else if (!stall) begin
                diff_p <= diff_nx;
                bor_p  <= sel[BLOCK];
                vld_p  <= vld_in;
            end
        end
    end

    // The last stage still sees the operand sign bits at the top of its slice.
    logic a_msb;
    logic b_msb;
    logic ovf_nx;
    logic ovf_p;
    assign a_msb  = g_stage[S-1].a_in[BLOCK-1];
    assign b_msb  = g_stage[S-1].b_in[BLOCK-1];
    assign ovf_nx = (a_msb ^ b_msb) & (g_stage[S-1].sel[BLOCK-1] ^ a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p <= 1'b0;
        end else if (!stall) begin
            ovf_p <= ovf_nx;
        end
    end

    assign diff      = g_stage[S-1].diff_p;
    assign bout      = g_stage[S-1].bor_p;
    assign out_valid = g_stage[S-1].vld_p;
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Directed bench for carry_select_subtractor_pipe (N=16, BLOCK=4): latency, arithmetic
// boundaries, back-pressure, bubbles and asynchronous reset mid-flight.
module tb_carry_select_subtractor_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    carry_select_subtractor_pipe #(.N(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, bout, diff} from a full-width subtraction.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic        ov;
        full = {1'b0, x} - {1'b0, y} - {16'b0, c};
        ov   = (x[15] ^ y[15]) & (full[15] ^ x[15]);
        return {ov, full};
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One operand, then wait (bounded) for its result and measure the latency in edges.
    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                           input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        out_ready = 1'b1;
        a = x;
        b = y;
        bin = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    logic [15:0] bp_a [0:9] = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF,
                                16'hA5A5, 16'h0F0F, 16'h0000, 16'hC3C3, 16'h5A5A};
    logic [15:0] bp_b [0:9] = '{16'h0234, 16'h0002, 16'h0001, 16'h0001, 16'hFFFF,
                                16'h5A5A, 16'hF0F0, 16'h0000, 16'h3C3C, 16'hA5A5};
    logic        bp_c [0:9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic [15:0] bb_a [0:3] = '{16'h0010, 16'hABCD, 16'h0000, 16'hFFFF};
    logic [15:0] bb_b [0:3] = '{16'h0001, 16'h0BCD, 16'h0000, 16'h0001};
    logic        bb_c [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [16:0] bb_e [0:3] = '{17'h0000F, 17'h0A000, 17'h1FFFF, 17'h0FFFD};

    initial begin
        int          ii;
        int          io;
        int          cyc;
        int          stale;
        logic        accept;
        logic        prev_stall;
        logic        exp_v;
        logic [17:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_one("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_one("bin_eq", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_one("ovf_min", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_one("ovf_max", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_one("ripple", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        idle(6);

        // Back-pressure: 10 operands back-to-back, consumer stalls cycles 3..9.
        ii = 0;
        io = 0;
        cyc = 0;
        prev_stall = 1'b0;
        held = '0;
        while (io < 10 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 9);
            in_valid  = (ii < 10);
            if (ii < 10) begin
                a   = bp_a[ii];
                b   = bp_b[ii];
                bin = bp_c[ii];
            end
            #1;
            if (prev_stall)
                check("bp_hold", {out_valid, ovf, bout, diff}, {1'b1, held});
            if (out_valid && !out_ready) begin
                check("bp_in_ready", in_ready, 0);
                held = {ovf, bout, diff};
            end
            prev_stall = out_valid && !out_ready;
            accept = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_result", {ovf, bout, diff}, model(bp_a[io], bp_b[io], bp_c[io]));
                io++;
            end
            @(posedge clk);
            #1;
            if (accept)
                ii++;
            cyc++;
        end
        check("bp_count", io, 10);
        out_ready = 1'b1;
        idle(6);
        check("bp_no_extra", out_valid, 0);

        // Bubbles: valid on every other cycle, results must keep the same spacing.
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8) && (c % 2 == 0);
            if (in_valid) begin
                a   = bb_a[c/2];
                b   = bb_b[c/2];
                bin = bb_c[c/2];
            end
            #1;
            exp_v = (c >= 4) && (c < 12) && ((c - 4) % 2 == 0);
            check("bub_valid", out_valid, exp_v);
            if (exp_v && out_valid)
                check("bub_data", {bout, diff}, bb_e[(c-4)/2]);
            @(posedge clk);
            #1;
        end
        idle(4);

        // Reset mid-flight: three operands in, first result visible, then async reset.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a   = (k == 0) ? 16'h7FFF : 16'h5555;
            b   = (k == 0) ? 16'hFFFF : 16'h1111;
            bin = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_diff", diff, 16'h8000);
        check("rst_pre_flags", {ovf, bout}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_diff", diff, 0);
        check("rst_mid_bout", bout, 0);
        check("rst_mid_ovf", ovf, 0);
        check("rst_mid_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid)
                stale++;
        end
        check("rst_no_stale", stale, 0);
        run_one("rst_next", 16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
